// File: rtl/fcmp_pkg.sv
// Shared types and binary32 field helpers for the FP compare scheduler.
// FCMP_NV_FLAG_EN (optional) adds invalid-operation flags to responses.
package fcmp_pkg;

   typedef enum logic [1:0] {
      FCMP_EQ  = 2'd0,
      FCMP_LT  = 2'd1,
      FCMP_LE  = 2'd2,
      FCMP_RSV = 2'd3
   } fcmp_op_t;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:MAN_W] == {EXP_W{1'b1}}) && (x[MAN_W-1:0] != '0);
   endfunction

   // Signalling NaN: quiet bit (mantissa MSB) clear.
   function automatic logic is_snan(input logic [31:0] x);
      return is_nan(x) && !x[MAN_W-1];
   endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational binary32 compare (feq/flt/fle); the only compare datapath.
// FCMP_NV_FLAG_EN adds the nv output.
module fcmp_core
   import fcmp_pkg::*;
(
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  fcmp_op_t    op,
`ifdef FCMP_NV_FLAG_EN
   output logic        nv,
`endif
   output logic        y
);

   logic any_nan;
   logic both_zero;
   logic eq;
   logic lt;

   assign any_nan   = is_nan(x1) || is_nan(x2);
   assign both_zero = (x1[30:0] == '0) && (x2[30:0] == '0);
   assign eq        = both_zero || (x1 == x2);

   // Sign-magnitude order; negative magnitudes compare reversed.
   always_comb begin
      lt = 1'b0;
      if (!both_zero) begin
         if (x1[31] != x2[31]) lt = x1[31];
         else if (x1[31])      lt = x2[30:0] < x1[30:0];
         else                  lt = x1[30:0] < x2[30:0];
      end
   end

   always_comb begin
      y = 1'b0;
      unique case (op)
         FCMP_EQ:  y = !any_nan && eq;
         FCMP_LT:  y = !any_nan && lt;
         FCMP_LE:  y = !any_nan && (lt || eq);
         FCMP_RSV: y = 1'b0;
      endcase
   end

`ifdef FCMP_NV_FLAG_EN
   always_comb begin
      nv = 1'b0;
      unique case (op)
         FCMP_EQ:  nv = is_snan(x1) || is_snan(x2);
         FCMP_LT:  nv = any_nan;
         FCMP_LE:  nv = any_nan;
         FCMP_RSV: nv = 1'b1;
      endcase
   end
`endif

endmodule

// File: rtl/fcmp_sched.sv
// Round-robin scheduler sharing one fcmp_core between two requesters.
// FCMP_NV_FLAG_EN adds registered rsp_nv_0/rsp_nv_1 outputs.
module fcmp_sched
   import fcmp_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0]       req_op_0,
   input  logic [1:0]       req_op_1,
   input  logic [31:0]      req_x1_0,
   input  logic [31:0]      req_x2_0,
   input  logic [31:0]      req_x1_1,
   input  logic [31:0]      req_x2_1,
   input  logic [TAG_W-1:0] req_tag_0,
   input  logic [TAG_W-1:0] req_tag_1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
`ifdef FCMP_NV_FLAG_EN
   output logic             rsp_nv_0,
   output logic             rsp_nv_1,
`endif
   output logic             rsp_y_0,
   output logic             rsp_y_1,
   output logic [TAG_W-1:0] rsp_tag_0,
   output logic [TAG_W-1:0] rsp_tag_1
);

   logic       last_grant;
   logic [1:0] free;
   logic [1:0] elig;
   logic [1:0] grant;
   logic       sel;
   logic [31:0] x1;
   logic [31:0] x2;
   fcmp_op_t   op;
   logic       y;
`ifdef FCMP_NV_FLAG_EN
   logic       nv;
`endif

   // A slot draining this cycle can accept a new result.
   assign free = ~rsp_valid | rsp_ready;
   assign elig = req_valid & free;

   always_comb begin
      grant = elig;
      if (elig == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      if (rst) grant = 2'b00;
   end

   assign req_ready = grant;
   assign sel       = grant[1];
   assign x1        = sel ? req_x1_1 : req_x1_0;
   assign x2        = sel ? req_x2_1 : req_x2_0;
   assign op        = fcmp_op_t'(sel ? req_op_1 : req_op_0);

   fcmp_core u_core (
      .x1 (x1),
      .x2 (x2),
      .op (op),
`ifdef FCMP_NV_FLAG_EN
      .nv (nv),
`endif
      .y  (y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid  <= 2'b00;
         rsp_y_0    <= 1'b0;
         rsp_y_1    <= 1'b0;
         rsp_tag_0  <= '0;
         rsp_tag_1  <= '0;
         last_grant <= 1'b1;
`ifdef FCMP_NV_FLAG_EN
         rsp_nv_0   <= 1'b0;
         rsp_nv_1   <= 1'b0;
`endif
      end else begin
         if (grant != 2'b00) last_grant <= grant[1];
         if (grant[0]) begin
            rsp_valid[0] <= 1'b1;
            rsp_y_0      <= y;
            rsp_tag_0    <= req_tag_0;
`ifdef FCMP_NV_FLAG_EN
            rsp_nv_0     <= nv;
`endif
         end else if (rsp_ready[0]) begin
            rsp_valid[0] <= 1'b0;
         end
         if (grant[1]) begin
            rsp_valid[1] <= 1'b1;
            rsp_y_1      <= y;
            rsp_tag_1    <= req_tag_1;
`ifdef FCMP_NV_FLAG_EN
            rsp_nv_1     <= nv;
`endif
         end else if (rsp_ready[1]) begin
            rsp_valid[1] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fcmp_sched.sv
// Directed self-checking bench for fcmp_sched.
// Checks nv outputs too when built with FCMP_NV_FLAG_EN.
module tb_fcmp_sched;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_op_0;
   logic [1:0]       req_op_1;
   logic [31:0]      req_x1_0;
   logic [31:0]      req_x2_0;
   logic [31:0]      req_x1_1;
   logic [31:0]      req_x2_1;
   logic [TAG_W-1:0] req_tag_0;
   logic [TAG_W-1:0] req_tag_1;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic             rsp_y_0;
   logic             rsp_y_1;
   logic [TAG_W-1:0] rsp_tag_0;
   logic [TAG_W-1:0] rsp_tag_1;
`ifdef FCMP_NV_FLAG_EN
   logic             rsp_nv_0;
   logic             rsp_nv_1;
`endif

   int errors = 0;
   int checks = 0;

   fcmp_sched #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op_0  (req_op_0),
      .req_op_1  (req_op_1),
      .req_x1_0  (req_x1_0),
      .req_x2_0  (req_x2_0),
      .req_x1_1  (req_x1_1),
      .req_x2_1  (req_x2_1),
      .req_tag_0 (req_tag_0),
      .req_tag_1 (req_tag_1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
`ifdef FCMP_NV_FLAG_EN
      .rsp_nv_0  (rsp_nv_0),
      .rsp_nv_1  (rsp_nv_1),
`endif
      .rsp_y_0   (rsp_y_0),
      .rsp_y_1   (rsp_y_1),
      .rsp_tag_0 (rsp_tag_0),
      .rsp_tag_1 (rsp_tag_1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request on requester i; checks handshake and the registered result.
   task automatic issue(input int i, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic ey,
                        input logic env);
      if (i == 0) begin
         req_op_0 = op; req_x1_0 = a; req_x2_0 = b; req_tag_0 = tag;
         req_valid = 2'b01;
      end else begin
         req_op_1 = op; req_x1_1 = a; req_x2_1 = b; req_tag_1 = tag;
         req_valid = 2'b10;
      end
      #1;
      chk($sformatf("ready_%0d", tag), 32'(req_ready), 32'(req_valid));
      tick();
      req_valid = 2'b00;
      if (i == 0) begin
         chk($sformatf("valid_%0d", tag), 32'(rsp_valid[0]), 32'd1);
         chk($sformatf("y_%0d", tag), 32'(rsp_y_0), 32'(ey));
         chk($sformatf("tag_%0d", tag), 32'(rsp_tag_0), 32'(tag));
`ifdef FCMP_NV_FLAG_EN
         chk($sformatf("nv_%0d", tag), 32'(rsp_nv_0), 32'(env));
`endif
      end else begin
         chk($sformatf("valid_%0d", tag), 32'(rsp_valid[1]), 32'd1);
         chk($sformatf("y_%0d", tag), 32'(rsp_y_1), 32'(ey));
         chk($sformatf("tag_%0d", tag), 32'(rsp_tag_1), 32'(tag));
`ifdef FCMP_NV_FLAG_EN
         chk($sformatf("nv_%0d", tag), 32'(rsp_nv_1), 32'(env));
`endif
      end
      if (env === 1'bx) chk("env_known", 32'd0, 32'd1);
   endtask

   initial begin
      logic       lg;
      logic [1:0] eg;
      logic [3:0] t0;
      logic [3:0] t1;
      logic [3:0] held;

      rst = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      req_op_0 = 2'd0; req_op_1 = 2'd0;
      req_x1_0 = '0; req_x2_0 = '0; req_x1_1 = '0; req_x2_1 = '0;
      req_tag_0 = '0; req_tag_1 = '0;
      tick();
      tick();
      req_valid = 2'b11;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_y", 32'({rsp_y_1, rsp_y_0}), 32'd0);
      chk("rst_tag0", 32'(rsp_tag_0), 32'd0);
      chk("rst_tag1", 32'(rsp_tag_1), 32'd0);
      req_valid = 2'b00;
      tick();
      rst = 1'b0;

      // Directed compares: op, x1, x2, tag, y, nv.
      issue(0, 2'd1, 32'h3F800000, 32'h40000000, 4'd5, 1'b1, 1'b0);
      issue(0, 2'd0, 32'h80000000, 32'h00000000, 4'd6, 1'b1, 1'b0);
      issue(1, 2'd2, 32'h7FC00000, 32'h3F800000, 4'd7, 1'b0, 1'b1);
      issue(1, 2'd0, 32'h7FC00000, 32'h3F800000, 4'd8, 1'b0, 1'b0);
      issue(0, 2'd0, 32'h7F800001, 32'h3F800000, 4'd9, 1'b0, 1'b1);
      issue(1, 2'd1, 32'hC0000000, 32'hBF800000, 4'd10, 1'b1, 1'b0);
      issue(0, 2'd2, 32'h3F800000, 32'h3F800000, 4'd11, 1'b1, 1'b0);
      issue(1, 2'd1, 32'h40000000, 32'h3F800000, 4'd12, 1'b0, 1'b0);
      issue(0, 2'd1, 32'h80000000, 32'h00000000, 4'd13, 1'b0, 1'b0);
      issue(1, 2'd3, 32'h3F800000, 32'h40000000, 4'd14, 1'b0, 1'b1);
      tick();
      chk("drained", 32'(rsp_valid), 32'd0);

      // Fresh reset so requester 0 wins the first conflict.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lg = 1'b1;
      t0 = 4'd1;
      t1 = 4'd9;
      req_op_0 = 2'd1; req_x1_0 = 32'h3F800000; req_x2_0 = 32'h40000000;
      req_op_1 = 2'd1; req_x1_1 = 32'h40000000; req_x2_1 = 32'h3F800000;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int c = 0; c < 4; c++) begin
         req_tag_0 = t0;
         req_tag_1 = t1;
         eg = lg ? 2'b01 : 2'b10;
         #1;
         chk($sformatf("alt_grant_%0d", c), 32'(req_ready), 32'(eg));
         tick();
         if (eg[0]) begin
            chk($sformatf("alt_tag0_%0d", c), 32'(rsp_tag_0), 32'(t0));
            chk($sformatf("alt_y0_%0d", c), 32'(rsp_y_0), 32'd1);
            t0 = t0 + 4'd1;
         end else begin
            chk($sformatf("alt_tag1_%0d", c), 32'(rsp_tag_1), 32'(t1));
            chk($sformatf("alt_y1_%0d", c), 32'(rsp_y_1), 32'd0);
            t1 = t1 + 4'd1;
         end
         lg = eg[1];
      end

      // Slot 1 stalls; requester 0 streams with drain+load on slot 0.
      held = t1 - 4'd1;
      rsp_ready = 2'b01;
      for (int c = 0; c < 3; c++) begin
         req_tag_0 = t0;
         #1;
         chk($sformatf("stall_ready_%0d", c), 32'(req_ready), 32'd1);
         tick();
         chk($sformatf("stall_valid_%0d", c), 32'(rsp_valid), 32'd3);
         chk($sformatf("stall_tag0_%0d", c), 32'(rsp_tag_0), 32'(t0));
         chk($sformatf("stall_tag1_%0d", c), 32'(rsp_tag_1), 32'(held));
         chk($sformatf("stall_y1_%0d", c), 32'(rsp_y_1), 32'd0);
         t0 = t0 + 4'd1;
      end

      // Stall released: last winner was 0, so 1 goes next.
      rsp_ready = 2'b11;
      #1;
      chk("release_grant", 32'(req_ready), 32'd2);

      // Reset with both slots full and both requesting.
      rsp_ready = 2'b00;
      tick();
      rst = 1'b1;
      #1;
      chk("rst2_ready", 32'(req_ready), 32'd0);
      tick();
      rst = 1'b0;
      chk("rst2_valid", 32'(rsp_valid), 32'd0);
      chk("rst2_tag1", 32'(rsp_tag_1), 32'd0);
      rsp_ready = 2'b11;
      #1;
      chk("rst2_grant", 32'(req_ready), 32'd1);
      tick();
      chk("rst2_resp", 32'(rsp_valid), 32'd1);
      req_valid = 2'b00;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
